// File: rtl/memory_access_stage_pkg.sv
// Shared types and defaults for the memory (M) pipeline stage.
package memory_access_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } mem_state_e;

endpackage

// File: rtl/memory_access_stage_mw_pipe_reg.sv
// M/W pipeline register: reset > load > bubble > hold (freeze).
module mw_pipe_reg #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  logic              hlt_in,
  input  logic              reg_write_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic [DATA_W-1:0] write_data_in,
  output logic              valid_mw,
  output logic              hlt_mw,
  output logic              reg_write_mw,
  output logic [REG_W-1:0]  write_reg_mw,
  output logic [DATA_W-1:0] write_data_mw
);

  logic              valid_q, valid_d;
  logic              hlt_q, hlt_d;
  logic              reg_write_q, reg_write_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  always_comb begin
    valid_d      = valid_q;
    hlt_d        = hlt_q;
    reg_write_d  = reg_write_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (load) begin
      valid_d      = 1'b1;
      hlt_d        = hlt_in;
      reg_write_d  = reg_write_in;
      write_reg_d  = write_reg_in;
      write_data_d = write_data_in;
    end else if (bubble) begin
      // Bubble kills the control bits only; payload is don't-care.
      valid_d     = 1'b0;
      hlt_d       = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      hlt_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      hlt_q        <= hlt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign valid_mw      = valid_q;
  assign hlt_mw        = hlt_q;
  assign reg_write_mw  = reg_write_q;
  assign write_reg_mw  = write_reg_q;
  assign write_data_mw = write_data_q;

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: data-memory handshake FSM, write-back mux, M/W register.
// Optional M-to-M store-data forwarding enabled by defining MEM_FWD_EN.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt_xm,
  input  logic              mem_read_xm,
  input  logic              mem_write_xm,
  input  logic              mem_to_reg_xm,
  input  logic              reg_write_xm,
  input  logic              pcs_xm,
  input  logic [REG_W-1:0]  write_reg_xm,
  input  logic [REG_W-1:0]  rt_xm,
  input  logic [DATA_W-1:0] next_pc_xm,
  input  logic [DATA_W-1:0] reg2_xm,
  input  logic [DATA_W-1:0] alu_out_xm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_m,
  output logic              valid_mw,
  output logic              hlt_mw,
  output logic              reg_write_mw,
  output logic [REG_W-1:0]  write_reg_mw,
  output logic [DATA_W-1:0] write_data_mw
);

  mem_state_e        state_q, state_d;
  logic              access;
  logic              mw_load, mw_bubble;
  logic [DATA_W-1:0] wb_data;

  assign access = mem_read_xm | mem_write_xm;

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    stall_m   = 1'b0;
    mw_load   = 1'b0;
    mw_bubble = 1'b0;
    case (state_q)
      IDLE, WAIT: begin
        if (access || state_q == WAIT) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            mw_load = 1'b1;
            state_d = hlt_xm ? HALTED : IDLE;
          end else begin
            stall_m   = 1'b1;
            mw_bubble = 1'b1;
            state_d   = WAIT;
          end
        end else begin
          mw_load = 1'b1;
          if (hlt_xm) state_d = HALTED;
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d   = IDLE;
      mem_req   = 1'b0;
      stall_m   = 1'b0;
      mw_load   = 1'b0;
      mw_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign mem_we   = mem_req & mem_write_xm;
  assign mem_addr = alu_out_xm;

  // A store never captures read data, even if mem_read_xm is also set.
  always_comb begin
    if (mem_to_reg_xm && !mem_write_xm) wb_data = mem_rdata;
    else if (pcs_xm)                    wb_data = next_pc_xm;
    else                                wb_data = alu_out_xm;
  end

`ifdef MEM_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] wdata_sel;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign fwd_hit   = mem_write_xm & reg_write_mw & valid_mw &
                     (rt_xm == write_reg_mw) & (write_reg_mw != '0);
  assign wdata_sel = fwd_hit ? write_data_mw : reg2_xm;

  // The producer is bubbled out of M/W while waiting, so hold the forwarded value.
  always_comb begin
    wdata_d = wdata_q;
    if (state_q == IDLE && state_d == WAIT) wdata_d = wdata_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) wdata_q <= '0;
    else     wdata_q <= wdata_d;
  end

  assign mem_wdata = (state_q == WAIT) ? wdata_q : wdata_sel;
`else
  logic unused_fwd;
  assign unused_fwd = ^rt_xm;
  assign mem_wdata  = reg2_xm;
`endif

  mw_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mw (
    .clk          (clk),
    .rst          (rst),
    .load         (mw_load),
    .bubble       (mw_bubble),
    .hlt_in       (hlt_xm),
    .reg_write_in (reg_write_xm),
    .write_reg_in (write_reg_xm),
    .write_data_in(wb_data),
    .valid_mw     (valid_mw),
    .hlt_mw       (hlt_mw),
    .reg_write_mw (reg_write_mw),
    .write_reg_mw (write_reg_mw),
    .write_data_mw(write_data_mw)
  );

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory (M) stage of the five-stage pipeline: consumes the Execute/Memory register outputs, performs the data-memory load or store over a ready/request handshake to a variable-latency data memory, selects the write-back value, and holds it in the Memory/Writeback pipeline register. While a memory access is outstanding it raises a stall that freezes every upstream pipeline register and inserts bubbles into write-back.

## Interface
- DATA_W, 16, datapath and memory word width
- REG_W, 4, register-specifier width
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hlt_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm, reg_write_xm, pcs_xm  in  1 each  X/M control bits
- write_reg_xm  in  REG_W  destination register
- rt_xm  in  REG_W  store-data source register specifier
- next_pc_xm, reg2_xm, alu_out_xm  in  DATA_W  PC+2, store data, ALU result / address
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr, mem_wdata  out  DATA_W  address (alu_out_xm), store data
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1
- mem_ready  in  1  access complete this cycle
- stall_m  out  1  freeze PC, F/D, D/X, X/M registers
- valid_mw, hlt_mw, reg_write_mw  out  1 each  M/W control bits
- write_reg_mw  out  REG_W  M/W destination
- write_data_mw  out  DATA_W  value to write back

## Operation
- FSM states: IDLE, WAIT, HALTED.
- IDLE, no access (mem_read_xm=mem_write_xm=0): mem_req=0, stall_m=0; M/W loads X/M bits, valid_mw=1.
- IDLE, access: mem_req=1, mem_we=mem_write_xm. If mem_ready=1 same cycle: complete, no stall. Else stall_m=1, go WAIT.
- WAIT: mem_req, mem_we, mem_addr, mem_wdata held stable (sourced from frozen X/M); stall_m=1; M/W loads bubble (valid_mw=0, reg_write_mw=0, hlt_mw=0). On mem_ready=1: stall_m=0, M/W captures result, go IDLE.
- mem_read_xm and mem_write_xm both 1 is illegal; store takes priority, no read data captured.
- write_data_mw = mem_to_reg_xm ? mem_rdata : pcs_xm ? next_pc_xm : alu_out_xm.
- reg_write_mw = reg_write_xm; write_reg_mw = write_reg_xm.
- Halt: hlt_xm captured into hlt_mw in a completing cycle moves FSM to HALTED. HALTED: mem_req=0, stall_m=0, M/W frozen, hlt_mw stays 1 until rst.
- A store carrying hlt_xm completes its access before entering HALTED.
- mem_ready while mem_req=0 is ignored.

## Timing
- Reset (rst=1 at edge): state IDLE; valid_mw, hlt_mw, reg_write_mw = 0; write_reg_mw = 0; write_data_mw = 0. mem_req and stall_m are 0 during the reset cycle regardless of inputs.
- Reset mid-WAIT: access abandoned, next cycle IDLE, mem_req=0.
- mem_req, mem_we, mem_addr, mem_wdata, stall_m are combinational from state, X/M inputs and mem_ready; all M/W outputs registered.
- Latency X/M → M/W: 1 cycle plus N−1 stall cycles, where N = cycles from first mem_req to mem_ready (N=1 → zero stall).
- stall_m high exactly on cycles where an access is outstanding and mem_ready=0.

## Configuration
- MEM_FWD_EN defined: M-to-M store-data forwarding; if mem_write_xm, reg_write_mw, valid_mw, and rt_xm == write_reg_mw with write_reg_mw ≠ 0, mem_wdata = write_data_mw, else reg2_xm. Forwarded value latched on entry to WAIT so the held wdata stays stable.
- Undefined: mem_wdata = reg2_xm always; hazard resolved by upstream stalls.

## Structure
- Shared package: FSM state enum (IDLE, WAIT, HALTED), DATA_W/REG_W defaults.
- One sub-module: mw_pipe_reg (M/W register with load/bubble/freeze controls, synchronous reset); FSM and muxing in the top.

## Test plan
- Reset then ALU op, alu_out_xm=0x1234, reg_write_xm=1, write_reg_xm=3 → next cycle write_data_mw=0x1234, write_reg_mw=3, valid_mw=1, stall_m never 1.
- Load addr 0x0040, mem_ready after 3 cycles with rdata=0xBEEF → stall_m=1 for 2 cycles, two bubbles (valid_mw=0), then write_data_mw=0xBEEF; mem_addr stable 0x0040 throughout.
- Store addr 0x0010, reg2_xm=0x5A5A, mem_ready same cycle → mem_req=1, mem_we=1, mem_wdata=0x5A5A, no stall, reg_write_mw=0.
- PCS with next_pc_xm=0x0102, mem_to_reg_xm=0 → write_data_mw=0x0102.
- MEM_FWD_EN: ADD writes R5=0x0077, following store with rt_xm=5, reg2_xm=0x0000 → mem_wdata=0x0077; without macro → 0x0000.
- rst asserted during WAIT → next cycle mem_req=0, stall_m=0, all M/W outputs 0; hlt_xm then passes → hlt_mw=1 held, later X/M activity ignored.
